// File: rtl/station_mux.sv
// Four-station to one-channel multiplexer: one-entry buffer per station,
// round-robin grant into a two-state output stage with a delivered-word counter.
module station_mux (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       Enable,
  input  logic [3:0] LibData,
  input  logic [3:0] FireData,
  input  logic [3:0] SchoolData,
  input  logic [3:0] RibData,
  input  logic       LibValid,
  input  logic       FireValid,
  input  logic       SchoolValid,
  input  logic       RibValid,
  output logic       LibReady,
  output logic       FireReady,
  output logic       SchoolReady,
  output logic       RibReady,
  output logic [3:0] DataOut,
  output logic [1:0] Sel,
  output logic       Valid,
  input  logic       Ready,
  output logic [7:0] Count
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0] state;
  logic [3:0] full;
  logic [3:0] buf_data [4];
  logic [3:0] st_data  [4];
  logic [3:0] st_valid;
  logic [3:0] st_ready;
  logic [1:0] rr_ptr;
  logic [1:0] win_idx;
  logic [1:0] cand;
  logic       win_found;
  logic       grant;
  logic       accept;

  always_comb begin
    st_data[0] = LibData;
    st_data[1] = FireData;
    st_data[2] = SchoolData;
    st_data[3] = RibData;
  end

  assign st_valid = {RibValid, SchoolValid, FireValid, LibValid};
  // Ready looks only at the current full flag, so a draining buffer is never refilled in the same cycle.
  assign st_ready = {4{Enable}} & ~full;

  assign LibReady    = st_ready[0];
  assign FireReady   = st_ready[1];
  assign SchoolReady = st_ready[2];
  assign RibReady    = st_ready[3];

  assign Valid  = (state == HOLD);
  assign accept = Valid & Ready;
  assign grant  = Enable & win_found & ((state == IDLE) | Ready);

  // Search starts one past the last winner and wraps 3 -> 0.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    cand      = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      cand = rr_ptr + 2'(k + 1);
      if (!win_found && full[cand]) begin
        win_idx   = cand;
        win_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (st_valid[i] && st_ready[i]) buf_data[i] <= st_data[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full <= '0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (st_valid[i] && st_ready[i])
          full[i] <= 1'b1;
        else if (grant && (win_idx == 2'(i)))
          full[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      DataOut <= '0;
      Sel     <= '0;
      rr_ptr  <= 2'd3;
    end else if (grant) begin
      state   <= HOLD;
      DataOut <= buf_data[win_idx];
      Sel     <= win_idx;
      rr_ptr  <= win_idx;
    end else if ((state == HOLD) && Ready) begin
      state   <= IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      Count <= '0;
    else if (accept)
      Count <= Count + 8'd1;
  end

endmodule

// File: tb/tb_station_mux.sv
// Self-checking bench for station_mux: directed scenarios plus a randomized run
// compared against a transaction-level reference model.
module tb_station_mux;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       Enable = 1'b0;
  logic [3:0] LibData = '0, FireData = '0, SchoolData = '0, RibData = '0;
  logic       LibValid = 1'b0, FireValid = 1'b0, SchoolValid = 1'b0, RibValid = 1'b0;
  logic       LibReady, FireReady, SchoolReady, RibReady;
  logic [3:0] DataOut;
  logic [1:0] Sel;
  logic       Valid;
  logic       Ready = 1'b0;
  logic [7:0] Count;

  int total = 0;
  int bad = 0;

  station_mux dut (
    .clk(clk), .reset_n(reset_n), .Enable(Enable),
    .LibData(LibData), .FireData(FireData), .SchoolData(SchoolData), .RibData(RibData),
    .LibValid(LibValid), .FireValid(FireValid), .SchoolValid(SchoolValid), .RibValid(RibValid),
    .LibReady(LibReady), .FireReady(FireReady), .SchoolReady(SchoolReady), .RibReady(RibReady),
    .DataOut(DataOut), .Sel(Sel), .Valid(Valid), .Ready(Ready), .Count(Count)
  );

  always #5 clk = ~clk;

  // Reference model: per-station slot, last winner, and the word on the channel.
  bit         m_full [4];
  logic [3:0] m_buf  [4];
  int         m_ptr;
  bit         m_valid;
  logic [3:0] m_dout;
  logic [1:0] m_sel;
  int         m_count;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_full[i] = 0;
      m_buf[i]  = '0;
    end
    m_ptr = 3; m_valid = 0; m_dout = '0; m_sel = '0; m_count = 0;
  endtask

  task automatic model_step();
    bit         v[4];
    logic [3:0] d[4];
    bit         can_take[4];
    bit         nf[4];
    bit         any;
    int         w;
    v[0] = LibValid; v[1] = FireValid; v[2] = SchoolValid; v[3] = RibValid;
    d[0] = LibData;  d[1] = FireData;  d[2] = SchoolData;  d[3] = RibData;
    any = 0; w = -1;
    for (int i = 0; i < 4; i++) begin
      can_take[i] = Enable && !m_full[i];
      nf[i] = m_full[i];
      if (m_full[i]) any = 1;
    end
    if (m_valid && Ready) m_count = (m_count + 1) % 256;
    if (Enable && any && (!m_valid || Ready)) begin
      for (int k = 1; k <= 4; k++) begin
        if (w < 0 && m_full[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
      end
      m_dout = m_buf[w];
      m_sel = 2'(w);
      m_ptr = w;
      m_valid = 1;
      nf[w] = 0;
    end else if (m_valid && Ready) begin
      m_valid = 0;
    end
    for (int i = 0; i < 4; i++) begin
      if (v[i] && can_take[i]) begin
        nf[i] = 1;
        m_buf[i] = d[i];
      end
      m_full[i] = nf[i];
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    LibValid = 0; FireValid = 0; SchoolValid = 0; RibValid = 0;
    LibData = '0; FireData = '0; SchoolData = '0; RibData = '0;
    Enable = 0; Ready = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    clear_inputs();
    #1 reset_n = 1'b0;
    #2;
    total++; if (Valid !== 1'b0)   begin bad++; $display("FAIL reset_valid got=%b want=0", Valid); end
    total++; if (DataOut !== 4'h0) begin bad++; $display("FAIL reset_data got=%h want=0", DataOut); end
    total++; if (Sel !== 2'b00)    begin bad++; $display("FAIL reset_sel got=%b want=00", Sel); end
    total++; if (Count !== 8'd0)   begin bad++; $display("FAIL reset_count got=%0d want=0", Count); end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    Enable = 1; #1;
    total++;
    if ({RibReady, SchoolReady, FireReady, LibReady} !== 4'b1111) begin
      bad++; $display("FAIL reset_ready got=%b want=1111", {RibReady, SchoolReady, FireReady, LibReady});
    end
    Enable = 0;
  endtask

  task automatic test_single();
    Enable = 1; Ready = 1; FireData = 4'hA; FireValid = 1;
    cycle();
    FireValid = 0;
    total++; if (Valid !== 1'b0) begin bad++; $display("FAIL single_early got=%b want=0", Valid); end
    cycle();
    total++;
    if (Valid !== 1'b1 || DataOut !== 4'hA || Sel !== 2'b01 || Count !== 8'd0) begin
      bad++; $display("FAIL single_word got v=%b d=%h s=%b c=%0d want v=1 d=a s=01 c=0", Valid, DataOut, Sel, Count);
    end
    cycle();
    total++;
    if (Count !== 8'd1 || Valid !== 1'b0) begin
      bad++; $display("FAIL single_count got c=%0d v=%b want c=1 v=0", Count, Valid);
    end
  endtask

  task automatic test_all_four();
    do_reset();
    Enable = 1; Ready = 1;
    LibData = 4'h1; FireData = 4'h2; SchoolData = 4'h3; RibData = 4'h4;
    LibValid = 1; FireValid = 1; SchoolValid = 1; RibValid = 1;
    cycle();
    LibValid = 0; FireValid = 0; SchoolValid = 0; RibValid = 0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      total++;
      if (Valid !== 1'b1 || Sel !== 2'(i) || DataOut !== 4'(i + 1) || Count !== 8'(i)) begin
        bad++; $display("FAIL all_four_%0d got v=%b s=%0d d=%h c=%0d want v=1 s=%0d d=%0d c=%0d",
                        i, Valid, Sel, DataOut, Count, i, i + 1, i);
      end
    end
    cycle();
    total++; if (Count !== 8'd4) begin bad++; $display("FAIL all_four_count got=%0d want=4", Count); end
  endtask

  task automatic test_backpressure();
    do_reset();
    Enable = 1; Ready = 0; SchoolData = 4'h7; SchoolValid = 1;
    cycle();
    SchoolValid = 0; SchoolData = 4'h0;
    cycle();
    for (int j = 0; j < 5; j++) begin
      Enable = (j != 2);
      #1;
      total++;
      if (Valid !== 1'b1 || DataOut !== 4'h7 || Sel !== 2'b10 || Count !== 8'd0 || SchoolReady !== Enable) begin
        bad++; $display("FAIL backpressure_%0d got v=%b d=%h s=%b c=%0d sr=%b want v=1 d=7 s=10 c=0 sr=%b",
                        j, Valid, DataOut, Sel, Count, SchoolReady, Enable);
      end
      cycle();
    end
    Enable = 1; Ready = 1;
    cycle();
    total++;
    if (Count !== 8'd1 || Valid !== 1'b0) begin
      bad++; $display("FAIL backpressure_release got c=%0d v=%b want c=1 v=0", Count, Valid);
    end
  endtask

  task automatic test_fairness_wrap();
    Enable = 1; Ready = 1; RibData = 4'h9; RibValid = 1;
    cycle();
    RibValid = 0;
    cycle();
    total++;
    if (Valid !== 1'b1 || Sel !== 2'b11 || DataOut !== 4'h9) begin
      bad++; $display("FAIL wrap_rib got v=%b s=%b d=%h want v=1 s=11 d=9", Valid, Sel, DataOut);
    end
    LibData = 4'hC; LibValid = 1; RibData = 4'hD; RibValid = 1;
    cycle();
    LibValid = 0; RibValid = 0;
    cycle();
    total++;
    if (Valid !== 1'b1 || Sel !== 2'b00 || DataOut !== 4'hC) begin
      bad++; $display("FAIL wrap_lib_first got v=%b s=%b d=%h want v=1 s=00 d=c", Valid, Sel, DataOut);
    end
    cycle();
    total++;
    if (Valid !== 1'b1 || Sel !== 2'b11 || DataOut !== 4'hD) begin
      bad++; $display("FAIL wrap_rib_next got v=%b s=%b d=%h want v=1 s=11 d=d", Valid, Sel, DataOut);
    end
  endtask

  task automatic test_enable();
    Enable = 1; Ready = 1; LibData = 4'h5; LibValid = 1;
    cycle();
    LibValid = 0; Enable = 0;
    for (int j = 0; j < 3; j++) begin
      #1;
      total++;
      if (Valid !== 1'b0 || {RibReady, SchoolReady, FireReady, LibReady} !== 4'b0000) begin
        bad++; $display("FAIL enable_off_%0d got v=%b rdy=%b want v=0 rdy=0000",
                        j, Valid, {RibReady, SchoolReady, FireReady, LibReady});
      end
      cycle();
    end
    Enable = 1;
    cycle();
    total++;
    if (Valid !== 1'b1 || Sel !== 2'b00 || DataOut !== 4'h5) begin
      bad++; $display("FAIL enable_resume got v=%b s=%b d=%h want v=1 s=00 d=5", Valid, Sel, DataOut);
    end
  endtask

  task automatic test_count_wrap_and_reset();
    int acc = 0;
    do_reset();
    Enable = 1; Ready = 1;
    LibValid = 1; FireValid = 1; SchoolValid = 1; RibValid = 1;
    for (int n = 0; n < 600 && acc < 256; n++) begin
      LibData = 4'($urandom); FireData = 4'($urandom);
      SchoolData = 4'($urandom); RibData = 4'($urandom);
      if (m_valid && Ready) acc++;
      cycle();
    end
    total++;
    if (acc != 256 || Count !== 8'd0) begin
      bad++; $display("FAIL count_wrap got c=%0d accepted=%0d want c=0 accepted=256", Count, acc);
    end
    cycle();
    cycle();
    Ready = 0;
    cycle();
    cycle();
    total++;
    if (Valid !== 1'b1 || Count !== 8'(m_count)) begin
      bad++; $display("FAIL pre_reset_hold got v=%b c=%0d want v=1 c=%0d", Valid, Count, m_count);
    end
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (Valid !== 1'b0 || Count !== 8'd0 || DataOut !== 4'h0 || Sel !== 2'b00) begin
      bad++; $display("FAIL midreset got v=%b c=%0d d=%h s=%b want v=0 c=0 d=0 s=00", Valid, Count, DataOut, Sel);
    end
    LibValid = 0; FireValid = 0; SchoolValid = 0; RibValid = 0;
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    Ready = 1;
    for (int j = 0; j < 3; j++) begin
      cycle();
      total++;
      if (Valid !== 1'b0 || Count !== 8'd0) begin
        bad++; $display("FAIL discard_%0d got v=%b c=%0d want v=0 c=0", j, Valid, Count);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] rdy;
    logic [3:0] exp_rdy;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      Enable = ($urandom_range(0, 7) != 0);
      Ready  = ($urandom_range(0, 3) != 0);
      LibValid = 1'($urandom); FireValid = 1'($urandom);
      SchoolValid = 1'($urandom); RibValid = 1'($urandom);
      LibData = 4'($urandom); FireData = 4'($urandom);
      SchoolData = 4'($urandom); RibData = 4'($urandom);
      #1;
      rdy = {RibReady, SchoolReady, FireReady, LibReady};
      for (int i = 0; i < 4; i++) exp_rdy[i] = Enable && !m_full[i];
      total++;
      if (rdy !== exp_rdy) begin
        bad++; $display("FAIL rand_ready cyc=%0d got=%b want=%b", n, rdy, exp_rdy);
      end
      total++;
      if (Valid !== m_valid || Count !== 8'(m_count)) begin
        bad++; $display("FAIL rand_valid_count cyc=%0d got v=%b c=%0d want v=%b c=%0d", n, Valid, Count, m_valid, m_count);
      end
      if (m_valid) begin
        total++;
        if (DataOut !== m_dout || Sel !== m_sel) begin
          bad++; $display("FAIL rand_word cyc=%0d got d=%h s=%b want d=%h s=%b", n, DataOut, Sel, m_dout, m_sel);
        end
      end
      cycle();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_all_four();
    test_backpressure();
    test_fairness_wrap();
    test_enable();
    test_count_wrap_and_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
